bus_arbiter_2to1: RTL and testbench

//  Shares one downstream memory bus (valid/ready request, later rvalid/rdata response) between two

---
 rtl/bus_arbiter_2to1_pkg.sv | 18 +
 rtl/bus_arbiter_2to1_if.sv | 26 ++
 rtl/bus_arbiter_2to1_id_fifo.sv | 81 ++++++++
 rtl/bus_arbiter_2to1.sv | 140 ++++++++++++++
 tb/tb_bus_arbiter_2to1.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_2to1_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package bus_arbiter_2to1_pkg;

   localparam int unsigned NumRequesters = 2;
   localparam int unsigned IdWidth       = $clog2(NumRequesters);

   // Requester identity: 0 = m0, 1 = m1
   typedef logic req_id_t;

   localparam req_id_t ReqM0 = 1'b0;
   localparam req_id_t ReqM1 = 1'b1;

   // The requester that is not `id`; used to hand round-robin preference over
   function automatic req_id_t other_req(input req_id_t id);
      return ~id;
   endfunction

endpackage

// File: rtl/bus_arbiter_2to1_if.sv
// Memory bus link: request (valid/ready/addr/wdata/wmask) plus in-order
// response (rvalid/rdata). The master drives requests, the slave answers.
interface bus_arbiter_2to1_if #(
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned DataWidth = 64
) ();

   logic                   valid;
   logic                   ready;
   logic [AddrWidth-1:0]   addr;
   logic [DataWidth-1:0]   wdata;
   logic [DataWidth/8-1:0] wmask;
   logic [DataWidth-1:0]   rdata;
   logic                   rvalid;

   modport master (
      output valid, addr, wdata, wmask,
      input  ready, rdata, rvalid
   );

   modport slave (
      input  valid, addr, wdata, wmask,
      output ready, rdata, rvalid
   );

endinterface

// File: rtl/bus_arbiter_2to1_id_fifo.sv
// Synchronous FIFO holding the requester ID of every accepted request so
// that responses can be steered back in acceptance order.
module bus_arbiter_2to1_id_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth) + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   // Pointers wrap modulo Depth, which need not fill the pointer range
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(Depth - 1)) begin
         return '0;
      end
      return p + PtrW'(1);
   endfunction

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   // Next-state for pointers and occupancy; push and pop together leave count unchanged
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state; reset discards every stored ID
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // ID storage; contents are only meaningful below the count, so no reset
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && full_o));

   a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(pop_i && empty_o));

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Two-requester round-robin arbiter in front of one memory bus. Requests pass
// straight through to the downstream port (no buffering); a grant is locked
// while the downstream stalls, and an ID FIFO steers in-order responses back.
module bus_arbiter_2to1
   import bus_arbiter_2to1_pkg::*;
#(
   parameter int unsigned AddrWidth       = 64,
   parameter int unsigned DataWidth       = 64,
   parameter int unsigned MaxOutstanding  = 2,
   parameter bit          AssertOrphanRsp = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   bus_arbiter_2to1_if.slave  m0_bus,
   bus_arbiter_2to1_if.slave  m1_bus,
   bus_arbiter_2to1_if.master s_bus
);

   localparam int unsigned MaskWidth = DataWidth / 8;

   // Arbitration state
   logic    lock_q, lock_d;
   req_id_t lock_id_q, lock_id_d;
   req_id_t rr_q, rr_d;

   // Grant and handshake
   req_id_t gnt_id;
   logic    any_req;
   logic    gnt_vld;
   logic    gnt_req_vld;
   logic    hs;

   // Muxed request fields
   logic [AddrWidth-1:0] mux_addr;
   logic [DataWidth-1:0] mux_wdata;
   logic [MaskWidth-1:0] mux_wmask;

   // Response steering
   logic    fifo_full, fifo_empty;
   req_id_t head_id;
   logic    pop;
   logic    orphan_rsp;

   // Pick the grantee: a held lock wins, otherwise a lone requester, otherwise the rr favourite
   always_comb begin
      gnt_id  = ReqM0;
      any_req = 1'b0;
      if (lock_q) begin
         gnt_id  = lock_id_q;
         any_req = 1'b1;
      end else if (m0_bus.valid && m1_bus.valid) begin
         gnt_id  = rr_q;
         any_req = 1'b1;
      end else if (m1_bus.valid) begin
         gnt_id  = ReqM1;
         any_req = 1'b1;
      end else if (m0_bus.valid) begin
         gnt_id  = ReqM0;
         any_req = 1'b1;
      end
   end

   // A full ID FIFO blocks the grant even if a response drains an entry this cycle
   assign gnt_vld     = any_req & ~fifo_full & rst_ni;
   assign gnt_req_vld = (gnt_id == ReqM1) ? m1_bus.valid : m0_bus.valid;

   assign mux_addr  = (gnt_id == ReqM1) ? m1_bus.addr  : m0_bus.addr;
   assign mux_wdata = (gnt_id == ReqM1) ? m1_bus.wdata : m0_bus.wdata;
   assign mux_wmask = (gnt_id == ReqM1) ? m1_bus.wmask : m0_bus.wmask;

   assign s_bus.valid = gnt_vld & gnt_req_vld;
   assign s_bus.addr  = mux_addr;
   assign s_bus.wdata = mux_wdata;
   assign s_bus.wmask = mux_wmask;

   assign hs = s_bus.valid & s_bus.ready;

   assign m0_bus.ready = s_bus.ready & gnt_vld & (gnt_id == ReqM0);
   assign m1_bus.ready = s_bus.ready & gnt_vld & (gnt_id == ReqM1);

   // Lock onto a stalled grantee so the downstream request cannot change; handshake releases it
   always_comb begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      rr_d      = rr_q;
      if (hs) begin
         lock_d = 1'b0;
         rr_d   = other_req(gnt_id);
      end else if (s_bus.valid) begin
         lock_d    = 1'b1;
         lock_id_d = gnt_id;
      end
   end

   // Arbitration registers; reset favours m0 and drops any lock
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q    <= 1'b0;
         lock_id_q <= ReqM0;
         rr_q      <= ReqM0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         rr_q      <= rr_d;
      end
   end

   bus_arbiter_2to1_id_fifo #(
      .Depth (MaxOutstanding),
      .Width (IdWidth)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (hs),
      .data_i  (gnt_id),
      .pop_i   (pop),
      .head_o  (head_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Responses with nothing outstanding (e.g. stale after reset) are dropped
   assign pop        = s_bus.rvalid & ~fifo_empty & rst_ni;
   assign orphan_rsp = s_bus.rvalid &  fifo_empty & rst_ni;

   assign m0_bus.rdata  = s_bus.rdata;
   assign m1_bus.rdata  = s_bus.rdata;
   assign m0_bus.rvalid = pop & (head_id == ReqM0);
   assign m1_bus.rvalid = pop & (head_id == ReqM1);

   a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (s_bus.valid && !s_bus.ready) |=>
         (s_bus.valid && $stable(s_bus.addr) && $stable(s_bus.wdata) && $stable(s_bus.wmask)));

   if (AssertOrphanRsp) begin : g_orphan_chk
      a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
         !orphan_rsp);
   end

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Bench for bus_arbiter_2to1: directed scenarios followed by random traffic,
// all compared each cycle against a transaction-level reference model.
module tb_bus_arbiter_2to1;

   localparam int unsigned AW   = 64;
   localparam int unsigned DW   = 64;
   localparam int unsigned MAXO = 2;

   logic clk    = 1'b0;
   logic rst_ni = 1'b0;

   always #5 clk = ~clk;

   bus_arbiter_2to1_if #(.AddrWidth(AW), .DataWidth(DW)) m0_if ();
   bus_arbiter_2to1_if #(.AddrWidth(AW), .DataWidth(DW)) m1_if ();
   bus_arbiter_2to1_if #(.AddrWidth(AW), .DataWidth(DW)) s_if ();

   bus_arbiter_2to1 #(
      .AddrWidth       (AW),
      .DataWidth       (DW),
      .MaxOutstanding  (MAXO),
      .AssertOrphanRsp (1'b0)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .m0_bus (m0_if),
      .m1_bus (m1_if),
      .s_bus  (s_if)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: queue of owners of outstanding requests, the requester
   // whose request is being held stalled (-1 none), and the last one served.
   int exp_q[$];
   int held = -1;
   int last = 1;
   bit acc0, acc1;

   logic        obs_sv, obs_r0, obs_r1, obs_rv0, obs_rv1, obs_orphan;
   logic [63:0] obs_addr, obs_rd0, obs_rd1;
   int          gseq[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic set_m(input int r, input logic v, input logic [63:0] a,
                        input logic [63:0] wd, input logic [7:0] wm);
      if (r == 0) begin
         m0_if.valid = v; m0_if.addr = a; m0_if.wdata = wd; m0_if.wmask = wm;
      end else begin
         m1_if.valid = v; m1_if.addr = a; m1_if.wdata = wd; m1_if.wmask = wm;
      end
   endtask

   task automatic idle_inputs();
      set_m(0, 1'b0, '0, '0, '0);
      set_m(1, 1'b0, '0, '0, '0);
      s_if.ready  = 1'b0;
      s_if.rvalid = 1'b0;
      s_if.rdata  = '0;
   endtask

   // One clock: inputs already driven just after a falling edge
   task automatic cycle();
      int gnt;
      bit gv, esv, er0, er1, erv0, erv1, eorph;
      logic v0, v1;
      logic [63:0] ea, ewd;
      logic [7:0]  ewm;
      #1;
      v0 = m0_if.valid;
      v1 = m1_if.valid;
      gv  = 1'b1;
      gnt = 0;
      if (held >= 0)      gnt = held;
      else if (v0 && v1)  gnt = (last == 0) ? 1 : 0;
      else if (v1)        gnt = 1;
      else if (v0)        gnt = 0;
      else                gv  = 1'b0;
      if (exp_q.size() >= MAXO) gv = 1'b0;
      esv   = gv && ((gnt == 1) ? v1 : v0);
      er0   = s_if.ready && gv && (gnt == 0);
      er1   = s_if.ready && gv && (gnt == 1);
      erv0  = s_if.rvalid && (exp_q.size() > 0) && (exp_q[0] == 0);
      erv1  = s_if.rvalid && (exp_q.size() > 0) && (exp_q[0] == 1);
      eorph = s_if.rvalid && (exp_q.size() == 0);

      obs_sv     = s_if.valid;
      obs_addr   = s_if.addr;
      obs_r0     = m0_if.ready;
      obs_r1     = m1_if.ready;
      obs_rv0    = m0_if.rvalid;
      obs_rv1    = m1_if.rvalid;
      obs_rd0    = m0_if.rdata;
      obs_rd1    = m1_if.rdata;
      obs_orphan = dut.orphan_rsp;

      check("s_valid",   obs_sv,     esv);
      check("m0_ready",  obs_r0,     er0);
      check("m1_ready",  obs_r1,     er1);
      check("m0_rvalid", obs_rv0,    erv0);
      check("m1_rvalid", obs_rv1,    erv1);
      check("m0_rdata",  obs_rd0,    s_if.rdata);
      check("m1_rdata",  obs_rd1,    s_if.rdata);
      check("orphan",    obs_orphan, eorph);
      if (esv || (held < 0 && !v0 && !v1)) begin
         ea  = (esv && gnt == 1) ? m1_if.addr  : m0_if.addr;
         ewd = (esv && gnt == 1) ? m1_if.wdata : m0_if.wdata;
         ewm = (esv && gnt == 1) ? m1_if.wmask : m0_if.wmask;
         check("s_addr",  obs_addr,   ea);
         check("s_wdata", s_if.wdata, ewd);
         check("s_wmask", s_if.wmask, ewm);
      end

      acc0 = esv && s_if.ready && (gnt == 0);
      acc1 = esv && s_if.ready && (gnt == 1);
      if (s_if.rvalid && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc0 || acc1) begin
         exp_q.push_back(gnt);
         last = gnt;
         held = -1;
      end else if (esv) begin
         held = gnt;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      set_m(0, 1'b1, 64'h1, '0, '0);
      set_m(1, 1'b1, 64'h2, '0, '0);
      s_if.ready  = 1'b1;
      s_if.rvalid = 1'b1;
      s_if.rdata  = 64'h55;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("rst_s_valid",   s_if.valid,   1'b0);
         check("rst_m0_ready",  m0_if.ready,  1'b0);
         check("rst_m1_ready",  m1_if.ready,  1'b0);
         check("rst_m0_rvalid", m0_if.rvalid, 1'b0);
         check("rst_m1_rvalid", m1_if.rvalid, 1'b0);
         @(negedge clk);
      end
      idle_inputs();
      rst_ni = 1'b1;
      exp_q.delete();
      held = -1;
      last = 1;
   endtask

   task automatic drain();
      set_m(0, 1'b0, '0, '0, '0);
      set_m(1, 1'b0, '0, '0, '0);
      for (int i = 0; i < 6 && exp_q.size() > 0; i++) begin
         s_if.rvalid = 1'b1;
         s_if.rdata  = {$urandom, $urandom};
         cycle();
      end
      s_if.rvalid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      do_reset();

      // Single m0 read with a two-cycle response
      set_m(0, 1'b1, 64'h1000, '0, '0);
      s_if.ready = 1'b1;
      cycle();
      check("sc1_m0_ready", obs_r0, 1'b1);
      check("sc1_s_addr",   obs_addr, 64'h1000);
      set_m(0, 1'b0, 64'h1000, '0, '0);
      cycle();
      s_if.rvalid = 1'b1;
      s_if.rdata  = 64'hAA;
      cycle();
      check("sc1_m0_rvalid", obs_rv0, 1'b1);
      check("sc1_m0_rdata",  obs_rd0, 64'hAA);
      check("sc1_m1_rvalid", obs_rv1, 1'b0);
      s_if.rvalid = 1'b0;

      // Both requesters always valid: grants alternate from reset
      do_reset();
      set_m(0, 1'b1, 64'h2000, 64'h10, 8'h0F);
      set_m(1, 1'b1, 64'h2800, 64'h20, 8'hF0);
      s_if.ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_if.rvalid = (exp_q.size() > 0);
         s_if.rdata  = {$urandom, $urandom};
         cycle();
         gseq.push_back(acc1 ? 1 : (acc0 ? 0 : -1));
         if (acc0) m0_if.addr = m0_if.addr + 64'h8;
         if (acc1) m1_if.addr = m1_if.addr + 64'h8;
      end
      for (int i = 0; i < 4; i++) begin
         check($sformatf("sc2_grant%0d", i), 64'(gseq[i]), 64'(i % 2));
      end
      drain();

      // Stalled m1 request keeps the bus while m0 arrives
      do_reset();
      set_m(1, 1'b1, 64'h3000, 64'h11, 8'hFF);
      s_if.ready = 1'b0;
      cycle();
      check("sc3_addr0", obs_addr, 64'h3000);
      set_m(0, 1'b1, 64'h4000, 64'h22, 8'h01);
      cycle();
      check("sc3_addr1", obs_addr, 64'h3000);
      cycle();
      check("sc3_addr2", obs_addr, 64'h3000);
      s_if.ready = 1'b1;
      cycle();
      check("sc3_m1_ready", obs_r1, 1'b1);
      set_m(1, 1'b0, '0, '0, '0);
      cycle();
      check("sc3_addr_m0", obs_addr, 64'h4000);
      check("sc3_m0_ready", obs_r0, 1'b1);
      drain();

      // Outstanding limit: full blocks even while a response pops
      do_reset();
      s_if.ready = 1'b1;
      set_m(0, 1'b1, 64'h5000, '0, '0);
      cycle();
      m0_if.addr = 64'h5100;
      cycle();
      m0_if.addr = 64'h5200;
      cycle();
      check("sc4_stall_ready",  obs_r0, 1'b0);
      check("sc4_stall_svalid", obs_sv, 1'b0);
      s_if.rvalid = 1'b1;
      s_if.rdata  = 64'hB0;
      cycle();
      check("sc4_full_pop_ready", obs_r0,  1'b0);
      check("sc4_full_pop_rv",    obs_rv0, 1'b1);
      cycle();
      check("sc4_pushpop_ready", obs_r0,  1'b1);
      check("sc4_pushpop_rv",    obs_rv0, 1'b1);
      s_if.rvalid = 1'b0;
      drain();

      // Response with nothing outstanding
      s_if.rvalid = 1'b1;
      s_if.rdata  = 64'hDEAD;
      cycle();
      check("sc5_m0_rvalid", obs_rv0,    1'b0);
      check("sc5_m1_rvalid", obs_rv1,    1'b0);
      check("sc5_orphan",    obs_orphan, 1'b1);
      s_if.rvalid = 1'b0;

      // Reset with a request in flight, then a stale response
      set_m(0, 1'b1, 64'h6000, '0, '0);
      s_if.ready = 1'b1;
      cycle();
      set_m(0, 1'b0, '0, '0, '0);
      do_reset();
      s_if.rvalid = 1'b1;
      s_if.rdata  = 64'h66;
      cycle();
      check("sc6_stale_rv0", obs_rv0, 1'b0);
      s_if.rvalid = 1'b0;
      s_if.ready  = 1'b1;
      set_m(0, 1'b1, 64'h7000, '0, '0);
      cycle();
      check("sc6_m0_ready", obs_r0, 1'b1);
      set_m(0, 1'b0, '0, '0, '0);
      cycle();
      s_if.rvalid = 1'b1;
      s_if.rdata  = 64'h77;
      cycle();
      check("sc6_m0_rvalid", obs_rv0, 1'b1);
      check("sc6_m0_rdata",  obs_rd0, 64'h77);
      s_if.rvalid = 1'b0;

      // Random traffic; requesters hold each request until accepted
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         if (!m0_if.valid && $urandom_range(0, 2) == 0)
            set_m(0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
         if (!m1_if.valid && $urandom_range(0, 2) == 0)
            set_m(1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
         s_if.ready  = ($urandom_range(0, 3) != 0);
         s_if.rvalid = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
         s_if.rdata  = {$urandom, $urandom};
         cycle();
         if (acc0) m0_if.valid = 1'b0;
         if (acc1) m1_if.valid = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
